// File: rtl/pokey_pot_bank.sv
// POKEY pot control bank: turns POTGO writes into per-channel go levels, captures
// scanner results into POT0-7, maintains ALLPOT. Optional POTERR via POKEY_POTERR_REG_EN.
module pokey_pot_bank #(
  parameter int unsigned NUM_POT    = 8,
  parameter int unsigned GO_TIMEOUT = 64,
  parameter int unsigned TO_W       = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   potgo_wr,
  input  logic                   rd_en,
  input  logic [3:0]             addr,
  output logic [7:0]             rd_data,
  output logic [NUM_POT-1:0]     pot_go,
  input  logic [NUM_POT-1:0]     pot_state,
  input  logic [NUM_POT-1:0]     pot_rdy,
  input  logic [8*NUM_POT-1:0]   pot_val,
  output logic [NUM_POT-1:0]     allpot
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_SCAN = 2'd2,
    ST_CAPT = 2'd3
  } ch_state_e;

  localparam int unsigned   DATA_W  = 8;
  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(GO_TIMEOUT - 1);
  localparam logic [TO_W-1:0] CNT_MAX  = '1;

  ch_state_e             state_q [NUM_POT];
  ch_state_e             state_d [NUM_POT];
  logic [TO_W-1:0]       cnt_q   [NUM_POT];
  logic [TO_W-1:0]       cnt_d   [NUM_POT];
  logic [NUM_POT-1:0]    rearm_q, rearm_d;
  logic [DATA_W-1:0]     pot_q   [NUM_POT];
  logic [DATA_W-1:0]     pot_d   [NUM_POT];
  logic [DATA_W-1:0]     rd_data_q, rd_data_d;
`ifdef POKEY_POTERR_REG_EN
  logic [NUM_POT-1:0]    timeout_c;
  logic [DATA_W-1:0]     poterr_q, poterr_d;
`endif

  // State register: channel FSMs, counters, captured values, read data
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_POT); i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
        pot_q[i]   <= '0;
      end
      rearm_q   <= '0;
      rd_data_q <= '0;
`ifdef POKEY_POTERR_REG_EN
      poterr_q  <= '0;
`endif
    end else begin
      for (int i = 0; i < int'(NUM_POT); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        pot_q[i]   <= pot_d[i];
      end
      rearm_q   <= rearm_d;
      rd_data_q <= rd_data_d;
`ifdef POKEY_POTERR_REG_EN
      poterr_q  <= poterr_d;
`endif
    end
  end

  // Next-state: per-channel go handshake, timeout and capture
  always_comb begin
    rearm_d = rearm_q;
`ifdef POKEY_POTERR_REG_EN
    timeout_c = '0;
`endif
    for (int i = 0; i < int'(NUM_POT); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      pot_d[i]   = pot_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (potgo_wr) begin
            state_d[i] = ST_PEND;
            cnt_d[i]   = '0;
          end
        end
        ST_PEND: begin
          // Scanner acceptance wins over a restart; a restart wins over timeout
          if (pot_state[i]) begin
            state_d[i] = ST_SCAN;
          end else if (potgo_wr) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] >= CNT_LAST) begin
            state_d[i] = ST_IDLE;
`ifdef POKEY_POTERR_REG_EN
            timeout_c[i] = 1'b1;
`endif
          end else if (cnt_q[i] != CNT_MAX) begin
            cnt_d[i] = cnt_q[i] + TO_W'(1);
          end
        end
        ST_SCAN: begin
          if (potgo_wr) rearm_d[i] = 1'b1;
          if (pot_rdy[i]) state_d[i] = ST_CAPT;
        end
        ST_CAPT: begin
          pot_d[i]   = pot_val[8*i +: 8];
          state_d[i] = (rearm_q[i] || potgo_wr) ? ST_PEND : ST_IDLE;
          cnt_d[i]   = '0;
          rearm_d[i] = 1'b0;
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from registered channel state
  always_comb begin
    pot_go = '0;
    allpot = '0;
    for (int i = 0; i < int'(NUM_POT); i++) begin
      case (state_q[i])
        ST_PEND: begin
          pot_go[i] = 1'b1;
          allpot[i] = 1'b1;
        end
        ST_SCAN: allpot[i] = 1'b1;
        ST_CAPT: allpot[i] = rearm_q[i];
        default: ;
      endcase
    end
  end

  // Register read path; sees pre-update values for same-cycle captures
  always_comb begin
    rd_data_d = rd_data_q;
`ifdef POKEY_POTERR_REG_EN
    poterr_d = poterr_q;
`endif
    if (rd_en) begin
      if (!addr[3]) begin
        rd_data_d = pot_q[addr[2:0]];
      end else if (addr == 4'd8) begin
        rd_data_d = DATA_W'(allpot);
`ifdef POKEY_POTERR_REG_EN
      end else if (addr == 4'd9) begin
        rd_data_d = poterr_q;
        poterr_d  = '0;
`endif
      end else begin
        rd_data_d = '0;
      end
    end
`ifdef POKEY_POTERR_REG_EN
    // Timeouts landing on the clearing read still survive
    poterr_d = poterr_d | DATA_W'(timeout_c);
`endif
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_pokey_pot_bank.sv
// Directed bench for pokey_pot_bank: reset, go/scan/capture, timeout, re-arm, read timing.
module tb_pokey_pot_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        potgo_wr;
  logic        rd_en;
  logic [3:0]  addr;
  logic [7:0]  rd_data;
  logic [7:0]  pot_go;
  logic [7:0]  pot_state;
  logic [7:0]  pot_rdy;
  logic [63:0] pot_val;
  logic [7:0]  allpot;

  int checks = 0;
  int errors = 0;

  pokey_pot_bank dut (
    .clk       (clk),
    .rst       (rst),
    .potgo_wr  (potgo_wr),
    .rd_en     (rd_en),
    .addr      (addr),
    .rd_data   (rd_data),
    .pot_go    (pot_go),
    .pot_state (pot_state),
    .pot_rdy   (pot_rdy),
    .pot_val   (pot_val),
    .allpot    (allpot)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [3:0] a);
    rd_en = 1'b1;
    addr  = a;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic potgo();
    potgo_wr = 1'b1;
    tick();
    potgo_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      potgo_wr  = 1'b1;
      rd_en     = 1'b1;
      addr      = 4'(k + 3);
      pot_state = 8'($urandom);
      pot_rdy   = 8'($urandom);
      pot_val   = {32'($urandom), 32'($urandom)};
      tick();
    end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    checks++; if (pot_go !== 8'h00) begin errors++; $display("FAIL reset_pot_go got %h want 00", pot_go); end
    checks++; if (allpot !== 8'h00) begin errors++; $display("FAIL reset_allpot got %h want 00", allpot); end
    potgo_wr = 0; rd_en = 0; addr = 0; pot_state = 0; pot_rdy = 0; pot_val = '0;
    rst = 1'b1;
    tick();
    for (int a = 0; a < 10; a++) begin
      do_read(4'(a));
      checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_read addr %0d got %h want 00", a, rd_data); end
    end
  endtask

  task automatic test_basic_scan();
    pot_val = 64'h1716_1514_2A12_1110;
    potgo();
    checks++; if (pot_go !== 8'hFF) begin errors++; $display("FAIL basic_go_c1 got %h want ff", pot_go); end
    checks++; if (allpot !== 8'hFF) begin errors++; $display("FAIL basic_allpot_c1 got %h want ff", allpot); end
    repeat (17) tick();
    checks++; if (pot_go !== 8'hFF) begin errors++; $display("FAIL basic_go_c18 got %h want ff", pot_go); end
    pot_state = 8'hFF;
    tick();
    checks++; if (pot_go !== 8'h00) begin errors++; $display("FAIL basic_go_c19 got %h want 00", pot_go); end
    checks++; if (allpot !== 8'hFF) begin errors++; $display("FAIL basic_allpot_c19 got %h want ff", allpot); end
    repeat (41) tick();
    pot_rdy = 8'h08;
    tick();
    pot_rdy = 8'h00;
    pot_state = 8'hF7;
    checks++; if (allpot !== 8'hF7) begin errors++; $display("FAIL basic_allpot_c61 got %h want f7", allpot); end
    tick();
    do_read(4'd3);
    checks++; if (rd_data !== 8'h2A) begin errors++; $display("FAIL basic_pot3 got %h want 2a", rd_data); end
    tick();
    checks++; if (rd_data !== 8'h2A) begin errors++; $display("FAIL basic_rd_hold got %h want 2a", rd_data); end
    pot_rdy = 8'hF7;
    tick();
    pot_rdy = 8'h00;
    tick();
    pot_state = 8'h00;
    checks++; if (allpot !== 8'h00) begin errors++; $display("FAIL basic_allpot_done got %h want 00", allpot); end
    do_read(4'd8);
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL basic_read_allpot got %h want 00", rd_data); end
    do_read(4'd5);
    checks++; if (rd_data !== 8'h15) begin errors++; $display("FAIL basic_pot5 got %h want 15", rd_data); end
  endtask

  task automatic test_timeout();
    potgo();
    pot_state = 8'hDF;
    tick();
    checks++; if (pot_go !== 8'h20) begin errors++; $display("FAIL to_go_c2 got %h want 20", pot_go); end
    repeat (62) tick();
    checks++; if (pot_go !== 8'h20) begin errors++; $display("FAIL to_go_c64 got %h want 20", pot_go); end
    checks++; if (allpot !== 8'hFF) begin errors++; $display("FAIL to_allpot_c64 got %h want ff", allpot); end
    tick();
    checks++; if (pot_go !== 8'h00) begin errors++; $display("FAIL to_go_c65 got %h want 00", pot_go); end
    checks++; if (allpot !== 8'hDF) begin errors++; $display("FAIL to_allpot_c65 got %h want df", allpot); end
    pot_val = 64'h5555_EE55_5555_5555;
    pot_rdy = 8'hDF;
    tick();
    pot_rdy = 8'h00;
    tick();
    pot_state = 8'h00;
    checks++; if (allpot !== 8'h00) begin errors++; $display("FAIL to_allpot_done got %h want 00", allpot); end
    do_read(4'd5);
    checks++; if (rd_data !== 8'h15) begin errors++; $display("FAIL to_pot5_kept got %h want 15", rd_data); end
    do_read(4'd4);
    checks++; if (rd_data !== 8'h55) begin errors++; $display("FAIL to_pot4 got %h want 55", rd_data); end
    do_read(4'd9);
`ifdef POKEY_POTERR_REG_EN
    checks++; if (rd_data !== 8'h20) begin errors++; $display("FAIL to_poterr got %h want 20", rd_data); end
`else
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL to_poterr got %h want 00", rd_data); end
`endif
    do_read(4'd9);
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL to_poterr_clr got %h want 00", rd_data); end
  endtask

  task automatic test_read_during_capture();
    potgo();
    pot_state = 8'hFF;
    tick();
    pot_rdy = 8'h02;
    rd_en   = 1'b1;
    addr    = 4'd8;
    tick();
    pot_rdy = 8'h00;
    checks++; if (rd_data !== 8'hFF) begin errors++; $display("FAIL rdcap_same got %h want ff", rd_data); end
    tick();
    rd_en = 1'b0;
    checks++; if (rd_data !== 8'hFD) begin errors++; $display("FAIL rdcap_next got %h want fd", rd_data); end
    pot_rdy = 8'hFD;
    tick();
    pot_rdy = 8'h00;
    tick();
    pot_state = 8'h00;
    checks++; if (allpot !== 8'h00) begin errors++; $display("FAIL rdcap_done got %h want 00", allpot); end
  endtask

  task automatic test_rearm_and_reset();
    potgo();
    pot_state = 8'hFF;
    tick();
    potgo();
    checks++; if (pot_go !== 8'h00) begin errors++; $display("FAIL rearm_go_scan got %h want 00", pot_go); end
    pot_val   = 64'h0000_0000_0000_0010;
    pot_rdy   = 8'h01;
    pot_state = 8'hFE;
    tick();
    pot_rdy = 8'h00;
    checks++; if (allpot !== 8'hFF) begin errors++; $display("FAIL rearm_allpot_capt got %h want ff", allpot); end
    tick();
    checks++; if (pot_go !== 8'h01) begin errors++; $display("FAIL rearm_go_pend got %h want 01", pot_go); end
    checks++; if (allpot !== 8'hFF) begin errors++; $display("FAIL rearm_allpot_pend got %h want ff", allpot); end
    do_read(4'd0);
    checks++; if (rd_data !== 8'h10) begin errors++; $display("FAIL rearm_pot0 got %h want 10", rd_data); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (pot_go !== 8'h00) begin errors++; $display("FAIL rst_mid_go got %h want 00", pot_go); end
    checks++; if (allpot !== 8'h00) begin errors++; $display("FAIL rst_mid_allpot got %h want 00", allpot); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_mid_rd got %h want 00", rd_data); end
    pot_val = 64'hA1A2_A3A4_A5A6_A7A8;
    pot_rdy = 8'hFF;
    tick();
    pot_rdy = 8'h00;
    tick();
    pot_state = 8'h00;
    do_read(4'd0);
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_pot0 got %h want 00", rd_data); end
    do_read(4'd3);
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_pot3 got %h want 00", rd_data); end
  endtask

  initial begin
    rst = 1'b0; potgo_wr = 0; rd_en = 0; addr = 0;
    pot_state = 0; pot_rdy = 0; pot_val = '0;
    #2;
    test_reset();
    test_basic_scan();
    test_timeout();
    test_read_during_capture();
    test_rearm_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
